// File: rtl/plane_move_ctrl.sv
// plane_move_ctrl: button-driven plane mover with debounce and frame-tick auto-repeat.
// Build option: define MOVE_REPEAT_EN to enable auto-repeat. Without it, each
// press gives exactly one move pulse.
//
// state  | meaning
// IDLE   | no valid direction request
// FIRST  | one-cycle issue state, move pulse is high
// DELAY  | counting ticks until the first auto-repeat
// REPEAT | counting ticks between auto-repeat moves
module plane_move_ctrl #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2,
  parameter int STEP          = 4,
  parameter int X_MAX         = 620,
  parameter int Y_MAX         = 460,
  parameter int X_INIT        = 310,
  parameter int Y_INIT        = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       btn_l_i,
  input  logic       btn_r_i,
  input  logic       btn_u_i,
  input  logic       btn_d_i,
  output logic       move_en_o,
  output logic [1:0] dir_o,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic       at_edge_o
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  XMAX10 = 10'(X_MAX);
  localparam logic [9:0]  YMAX10 = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;

  // Bit order matches the direction code: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
  logic [3:0] raw, sync1, sync2, db;
  logic [DBW-1:0] db_cnt [4];
  logic       req_valid;
  logic [1:0] req_dir;

  state_t          state_q, state_n;
  logic [TW-1:0]   tcnt_q, tcnt_n;
  logic [1:0]      dir_q, dir_n;
  logic            move_q, move_n;

  logic [9:0]  pos_x_q, pos_y_q, x_nxt, y_nxt;
  logic [10:0] x_dec, x_inc, y_dec, y_inc;
  logic        clip, at_edge_q;

  assign raw = {btn_r_i, btn_l_i, btn_d_i, btn_u_i};

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        db[i]     <= 1'b0;
        db_cnt[i] <= '0;
      end else if (sync2[i] != db[i]) begin
        if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end else begin
        db_cnt[i] <= '0;
      end
    end
  end

  // A request is valid only with exactly one debounced button held.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'b00;
    case (db)
      4'b0001: req_dir = 2'b00;
      4'b0010: req_dir = 2'b01;
      4'b0100: req_dir = 2'b10;
      4'b1000: req_dir = 2'b11;
      default: req_valid = 1'b0;
    endcase
  end

  // FSM state, tick counter, latched direction and registered move pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      dir_q   <= 2'b00;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tcnt_q  <= tcnt_n;
      dir_q   <= dir_n;
      move_q  <= move_n;
    end
  end

  // Next-state logic. A change or repeat is held off for one cycle while the
  // pulse is high so two pulses can never be adjacent.
  always_comb begin
    state_n = state_q;
    tcnt_n  = tcnt_q;
    dir_n   = dir_q;
    move_n  = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_n = '0;
        if (req_valid) begin
          state_n = FIRST;
          dir_n   = req_dir;
          move_n  = 1'b1;
        end
      end
      FIRST: begin
        state_n = DELAY;
        tcnt_n  = '0;
      end
      DELAY, REPEAT: begin
        if (!req_valid) begin
          state_n = IDLE;
          tcnt_n  = '0;
        end else if (req_dir != dir_q) begin
          if (!move_q) begin
            state_n = FIRST;
            dir_n   = req_dir;
            move_n  = 1'b1;
            tcnt_n  = '0;
          end
        end else if (tick_i && !move_q) begin
          if (state_q == DELAY) begin
`ifdef MOVE_REPEAT_EN
            if (tcnt_q == TW'(REPEAT_DELAY - 1)) begin
              state_n = REPEAT;
              move_n  = 1'b1;
              tcnt_n  = '0;
            end else begin
              tcnt_n = tcnt_q + TW'(1);
            end
`else
            tcnt_n = tcnt_q;
`endif
          end else if (tcnt_q == TW'(REPEAT_PERIOD - 1)) begin
            move_n = 1'b1;
            tcnt_n = '0;
          end else begin
            tcnt_n = tcnt_q + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Saturating step in 11-bit arithmetic; a wrapped decrement shows in bit 10.
  always_comb begin
    x_dec = {1'b0, pos_x_q} - STEP11;
    x_inc = {1'b0, pos_x_q} + STEP11;
    y_dec = {1'b0, pos_y_q} - STEP11;
    y_inc = {1'b0, pos_y_q} + STEP11;
    x_nxt = pos_x_q;
    y_nxt = pos_y_q;
    clip  = 1'b0;
    case (dir_q)
      2'b00: begin
        clip  = y_dec[10];
        y_nxt = y_dec[10] ? 10'd0 : y_dec[9:0];
      end
      2'b01: begin
        clip  = (y_inc > {1'b0, YMAX10});
        y_nxt = clip ? YMAX10 : y_inc[9:0];
      end
      2'b10: begin
        clip  = x_dec[10];
        x_nxt = x_dec[10] ? 10'd0 : x_dec[9:0];
      end
      default: begin
        clip  = (x_inc > {1'b0, XMAX10});
        x_nxt = clip ? XMAX10 : x_inc[9:0];
      end
    endcase
  end

  // Position and edge flag update on each move pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 10'(Y_INIT);
      at_edge_q <= 1'b0;
    end else if (move_q) begin
      pos_x_q   <= x_nxt;
      pos_y_q   <= y_nxt;
      at_edge_q <= clip;
    end
  end

  assign move_en_o = move_q;
  assign dir_o     = dir_q;
  assign pos_x_o   = pos_x_q;
  assign pos_y_o   = pos_y_q;
  assign at_edge_o = at_edge_q;

endmodule

// File: tb/tb_plane_move_ctrl.sv
// Directed bench for plane_move_ctrl with short debounce/repeat settings.
module tb_plane_move_ctrl;
  logic       clk = 1'b0;
  logic       rst, tick;
  logic       bl, br, bu, bd;
  logic       move_en, at_edge;
  logic [1:0] dir;
  logic [9:0] px, py;

  logic       ebl, ebr, zero;
  logic       e_move, e_at;
  logic [1:0] e_dir;
  logic [9:0] e_px, e_py;

  int total = 0;
  int bad   = 0;
  int exp_x, exp_y;

  always #5 clk = ~clk;

  plane_move_ctrl #(.DB_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .tick_i(tick),
    .btn_l_i(bl), .btn_r_i(br), .btn_u_i(bu), .btn_d_i(bd),
    .move_en_o(move_en), .dir_o(dir), .pos_x_o(px), .pos_y_o(py), .at_edge_o(at_edge)
  );

  // Second instance starting next to the right limit.
  plane_move_ctrl #(.DB_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_PERIOD(2), .X_INIT(618)) dut_e (
    .clk(clk), .rst(rst), .tick_i(zero),
    .btn_l_i(ebl), .btn_r_i(ebr), .btn_u_i(zero), .btn_d_i(zero),
    .move_en_o(e_move), .dir_o(e_dir), .pos_x_o(e_px), .pos_y_o(e_py), .at_edge_o(e_at)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; bl = 0; br = 0; bu = 0; bd = 0; ebl = 0; ebr = 0; zero = 0;
    step(); step();
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL reset_move_en got=%0b want=0", move_en); end
    total++; if (dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%0d want=0", dir); end
    total++; if (px !== 10'd310) begin bad++; $display("FAIL reset_pos_x got=%0d want=310", px); end
    total++; if (py !== 10'd400) begin bad++; $display("FAIL reset_pos_y got=%0d want=400", py); end
    total++; if (at_edge !== 1'b0) begin bad++; $display("FAIL reset_at_edge got=%0b want=0", at_edge); end
    total++; if (e_px !== 10'd618) begin bad++; $display("FAIL reset_edge_pos_x got=%0d want=618", e_px); end
    rst = 1'b0;
    exp_x = 310; exp_y = 400;
    step();
  endtask

  task automatic test_first_move();
    int early = 0;
    int extra = 0;
    br = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); early += int'(move_en); end
    total++; if (early != 0) begin bad++; $display("FAIL first_early_pulse got=%0d want=0", early); end
    step();
    total++; if (move_en !== 1'b1) begin bad++; $display("FAIL first_pulse got=%0b want=1", move_en); end
    total++; if (dir !== 2'b11) begin bad++; $display("FAIL first_dir got=%0d want=3", dir); end
    step();
    exp_x = exp_x + 4;
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL first_pulse_width got=%0b want=0", move_en); end
    total++; if (px !== 10'(exp_x)) begin bad++; $display("FAIL first_pos_x got=%0d want=%0d", px, exp_x); end
    for (int i = 0; i < 20; i++) begin step(); extra += int'(move_en); end
    total++; if (extra != 0) begin bad++; $display("FAIL hold_no_tick_pulses got=%0d want=0", extra); end
  endtask

  task automatic test_repeat();
    int other = 0;
    int extra = 0;
    logic want;
    for (int k = 1; k <= 7; k++) begin
      for (int i = 0; i < 9; i++) begin step(); other += int'(move_en); end
      tick = 1'b1;
      step();
      tick = 1'b0;
`ifdef MOVE_REPEAT_EN
      want = (k == 3 || k == 5 || k == 7);
`else
      want = 1'b0;
`endif
      total++;
      if (move_en !== want) begin bad++; $display("FAIL repeat_tick%0d got=%0b want=%0b", k, move_en, want); end
      if (want) begin
        exp_x = exp_x + 4;
        total++; if (dir !== 2'b11) begin bad++; $display("FAIL repeat_dir%0d got=%0d want=3", k, dir); end
      end
    end
    step(); other += int'(move_en);
    total++; if (other != 0) begin bad++; $display("FAIL repeat_untimed_pulses got=%0d want=0", other); end
    total++; if (px !== 10'(exp_x)) begin bad++; $display("FAIL repeat_pos_x got=%0d want=%0d", px, exp_x); end
    br = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); extra += int'(move_en); end
    total++; if (extra != 0) begin bad++; $display("FAIL release_pulses got=%0d want=0", extra); end
  endtask

  task automatic test_two_buttons();
    int n = 0;
    logic [1:0] seen = 2'b00;
    bl = 1'b1; bu = 1'b1;
    for (int i = 0; i < 15; i++) begin step(); n += int'(move_en); end
    total++; if (n != 0) begin bad++; $display("FAIL two_buttons_pulses got=%0d want=0", n); end
    bu = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (move_en) begin n++; seen = dir; end
    end
    exp_x = exp_x - 4;
    total++; if (n != 1) begin bad++; $display("FAIL left_pulses got=%0d want=1", n); end
    total++; if (seen !== 2'b10) begin bad++; $display("FAIL left_dir got=%0d want=2", seen); end
    total++; if (px !== 10'(exp_x)) begin bad++; $display("FAIL left_pos_x got=%0d want=%0d", px, exp_x); end
    bl = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_glitch();
    int n = 0;
    bd = 1'b1;
    step(); step(); step();
    bd = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); n += int'(move_en); end
    total++; if (n != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", n); end
    total++; if (py !== 10'(exp_y)) begin bad++; $display("FAIL glitch_pos_y got=%0d want=%0d", py, exp_y); end
  endtask

  task automatic test_edge();
    int n = 0;
    ebr = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); n += int'(e_move); end
    total++; if (n != 1) begin bad++; $display("FAIL edge_pulses got=%0d want=1", n); end
    total++; if (e_px !== 10'd620) begin bad++; $display("FAIL edge_clip_x got=%0d want=620", e_px); end
    total++; if (e_at !== 1'b1) begin bad++; $display("FAIL edge_clip_flag got=%0b want=1", e_at); end
    ebr = 1'b0;
    for (int i = 0; i < 12; i++) step();
    ebr = 1'b1;
    for (int i = 0; i < 8; i++) step();
    total++; if (e_px !== 10'd620) begin bad++; $display("FAIL edge_block_x got=%0d want=620", e_px); end
    total++; if (e_at !== 1'b1) begin bad++; $display("FAIL edge_block_flag got=%0b want=1", e_at); end
    ebr = 1'b0;
    for (int i = 0; i < 12; i++) step();
    ebl = 1'b1;
    for (int i = 0; i < 8; i++) step();
    total++; if (e_px !== 10'd616) begin bad++; $display("FAIL edge_left_x got=%0d want=616", e_px); end
    total++; if (e_at !== 1'b0) begin bad++; $display("FAIL edge_left_flag got=%0b want=0", e_at); end
    ebl = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_reset_mid_hold();
    int early = 0;
    br = 1'b1;
    for (int i = 0; i < 8; i++) step();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) step();
      tick = 1'b1; step(); tick = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (move_en !== 1'b0) begin bad++; $display("FAIL midrst_move_en got=%0b want=0", move_en); end
    total++; if (dir !== 2'b00) begin bad++; $display("FAIL midrst_dir got=%0d want=0", dir); end
    total++; if (px !== 10'd310) begin bad++; $display("FAIL midrst_pos_x got=%0d want=310", px); end
    total++; if (py !== 10'd400) begin bad++; $display("FAIL midrst_pos_y got=%0d want=400", py); end
    total++; if (at_edge !== 1'b0) begin bad++; $display("FAIL midrst_at_edge got=%0b want=0", at_edge); end
    for (int i = 0; i < 6; i++) begin step(); early += int'(move_en); end
    total++; if (early != 0) begin bad++; $display("FAIL midrst_early_pulse got=%0d want=0", early); end
    step();
    total++; if (move_en !== 1'b1) begin bad++; $display("FAIL midrst_pulse got=%0b want=1", move_en); end
    step();
    total++; if (px !== 10'd314) begin bad++; $display("FAIL midrst_pos_x_after got=%0d want=314", px); end
    br = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_repeat();
    test_two_buttons();
    test_glitch();
    test_edge();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plane_move_ctrl.md
PLANE_MOVE_CTRL -- requirements
Module: plane_move_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DB_CYCLES, 16: consecutive stable clk cycles before a button level is accepted.
- REPEAT_DELAY, 8: tick_i count from first move to first auto-repeat move.
- REPEAT_PERIOD, 2: tick_i count between auto-repeat moves.
- STEP, 4: pixels per move.
- X_MAX, 620 and Y_MAX, 460: inclusive position limits; the minimum is 0.
- X_INIT, 310 and Y_INIT, 400: position after reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on its rising edge.
- rst, in, 1: synchronous reset, active-high.
- tick_i, in, 1: one-cycle frame tick.
- btn_l_i, btn_r_i, btn_u_i, btn_d_i, in, 1 each: raw asynchronous buttons, 1 = pressed.
- move_en_o, out, 1: one-cycle move pulse.
- dir_o, out, 2: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT; valid while move_en_o=1.
- pos_x_o, out, 10: plane X position.
- pos_y_o, out, 10: plane Y position.
- at_edge_o, out, 1: last move was clipped or blocked at a limit.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer.
REQ-004 A per-button debounce counter SHALL update the debounced level on the edge where the synchronized value has differed from it for DB_CYCLES consecutive cycles; any agreement clears the counter.
REQ-005 The requested direction SHALL be valid only when exactly one debounced button is high; 0 or 2+ high = no request.
REQ-006 The FSM SHALL have four states:
- IDLE: no request.
- FIRST: one-cycle issue state.
- DELAY: counting REPEAT_DELAY ticks.
- REPEAT: counting REPEAT_PERIOD ticks.
REQ-007 IDLE with a valid request SHALL go to FIRST, latching the direction.
REQ-008 FIRST SHALL assert move_en_o for exactly one cycle, clear the tick counter and go to DELAY.
REQ-009 DELAY SHALL count tick_i; on reaching REPEAT_DELAY it SHALL go to FIRST-equivalent behaviour: pulse, clear the counter, and enter REPEAT.
REQ-010 REPEAT SHALL pulse and clear the counter each time the count reaches REPEAT_PERIOD.
REQ-011 In DELAY or REPEAT, a request that drops to invalid SHALL return the FSM to IDLE with no pulse.
REQ-012 In DELAY or REPEAT, a request that changes to a different direction SHALL go to FIRST with the new direction latched; the old counter is discarded.
REQ-013 On each pulse, the position SHALL move by STEP in dir_o, evaluated in 11-bit arithmetic:
- UP decrements Y; DOWN increments Y.
- LEFT decrements X; RIGHT increments X.
- The result saturates to [0, X_MAX] or [0, Y_MAX].
REQ-014 The new position SHALL be visible on pos_x_o/pos_y_o in the cycle after move_en_o=1.
REQ-015 at_edge_o SHALL be set on a pulse whose result was clipped or unchanged, and cleared on a pulse that moves the full STEP; it holds its value between pulses.
REQ-016 move_en_o SHALL never be high on two consecutive cycles.
REQ-017 tick_i arriving in the FIRST cycle SHALL not be counted.

Reset
REQ-018 When rst=1 at a clk edge:
- State goes to IDLE; counters, synchronizers and debounced levels clear to 0.
- move_en_o=0, dir_o=00, pos_x_o=X_INIT, pos_y_o=Y_INIT, at_edge_o=0.
REQ-019 Reset mid-hold SHALL need a fresh DB_CYCLES of stable press before the next pulse.

Configuration
REQ-020 Macro MOVE_REPEAT_EN SHALL control auto-repeat:
- Defined: behaviour is as in REQ-006 to REQ-012.
- Undefined: DELAY never times out and REPEAT is unreachable, giving exactly one pulse per press. Direction change and release still behave per REQ-011 and REQ-012.

Verification
REQ-021 The bench SHALL use DB_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2 and SHALL cover:
- Reset, then btn_r_i held: exactly one pulse, dir=11, 2+4+1 cycles after press; pos_x 310->314.
- Hold right with tick_i every 10 cycles: second pulse on the 3rd tick; subsequent pulses every 2nd tick. Without MOVE_REPEAT_EN: only one pulse.
- btn_l_i and btn_u_i pressed together: no pulse. Release btn_u_i: LEFT pulse after debounce.
- 3-cycle glitch on btn_d_i: no pulse, state stays IDLE.
- X=618, press RIGHT: pos_x=620, at_edge_o=1. Press again: pos_x stays 620, at_edge_o=1.
- rst asserted during REPEAT: outputs return to reset values. The still-held button produces its next pulse only after a full debounce.
